// File: rtl/range_sig_decoder.sv
// Purpose: folds per-nibble {eqU, ltU, eqL, gtL} flags into one registered range verdict per key.
// Latency: the result is registered on the edge that accepts the key's ending beat and is visible the next cycle.
// Backpressure: a held, unconsumed result drops in_ready and freezes the FSM; there is no overwrite.
module range_sig_decoder #(
  parameter int MAX_NIBBLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_flags,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_match,
  output logic [2:0] out_sig,
  output logic [3:0] out_len,
  output logic       out_err
);

  // State codes double as the signature codes reported on out_sig.
  localparam logic [2:0] S_IN   = 3'b111;
  localparam logic [2:0] S_UB   = 3'b100;
  localparam logic [2:0] S_LB   = 3'b001;
  localparam logic [2:0] S_BOTH = 3'b010;
  localparam logic [2:0] S_OUT  = 3'b000;

  // The beat that lands at this count is the last one a key may have.
  localparam logic [3:0] LAST_CNT = 4'(MAX_NIBBLES - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [2:0] beat_state;
  logic [3:0] cnt;
  logic       err;
  logic       accept;
  logic       illegal;
  logic       overrun;
  logic       key_end;
  logic       err_key;

  logic eq_u, lt_u, eq_l, gt_l;
  assign eq_u = in_flags[3];
  assign lt_u = in_flags[2];
  assign eq_l = in_flags[1];
  assign gt_l = in_flags[0];

  // State register: the FSM only moves on accepted beats, so it freezes while a result is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_BOTH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: prefix relation after this beat, then return to BOTH once the key ends.
  always_comb begin
    illegal    = (eq_u & lt_u) | (eq_l & gt_l);
    beat_state = S_OUT;
    case (state)
      S_BOTH: begin
        if (lt_u & gt_l)      beat_state = S_IN;
        else if (eq_u & eq_l) beat_state = S_BOTH;
        else if (eq_u & gt_l) beat_state = S_UB;
        else if (eq_l & lt_u) beat_state = S_LB;
        else                  beat_state = S_OUT;
      end
      S_UB: begin
        if (lt_u)      beat_state = S_IN;
        else if (eq_u) beat_state = S_UB;
        else           beat_state = S_OUT;
      end
      S_LB: begin
        if (gt_l)      beat_state = S_IN;
        else if (eq_l) beat_state = S_LB;
        else           beat_state = S_OUT;
      end
      S_IN:    beat_state = S_IN;
      default: beat_state = S_OUT;
    endcase
    // Contradictory flags mean the upstream comparison cannot be trusted.
    if (illegal) beat_state = S_OUT;

    overrun = accept & ~in_last & (cnt == LAST_CNT);
    key_end = accept & (in_last | (cnt == LAST_CNT));
    err_key = err | illegal | overrun;

    state_nxt = state;
    if (key_end)     state_nxt = S_BOTH;
    else if (accept) state_nxt = beat_state;
  end

  // Handshake outputs: a new key may start on the cycle a held result drains.
  always_comb begin
    in_ready = ~out_valid | out_ready;
    accept   = in_valid & in_ready;
  end

  // Per-key beat counter and sticky error, cleared at every key boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= 4'd0;
      err <= 1'b0;
    end else if (key_end) begin
      cnt <= 4'd0;
      err <= 1'b0;
    end else if (accept) begin
      cnt <= cnt + 4'd1;
      err <= err | illegal;
    end
  end

  // Result register: loads on key end (even while draining the previous one), else clears on consume.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_match <= 1'b0;
      out_sig   <= S_OUT;
      out_len   <= 4'd0;
      out_err   <= 1'b0;
    end else if (key_end) begin
      out_valid <= 1'b1;
      out_match <= (beat_state != S_OUT) & ~err_key;
      out_sig   <= beat_state;
      out_len   <= cnt + 4'd1;
      out_err   <= err_key;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_range_sig_decoder.sv
// Bench for range_sig_decoder: directed keys plus random keys built from numeric bounds.
// Expected verdicts come from plain integer comparison of key against [LB, UB].
// A scoreboard queue tracks the one outstanding result; out_ready is randomly throttled.
module tb_range_sig_decoder;
  localparam int MAXN = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_flags;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic       out_match;
  logic [2:0] out_sig;
  logic [3:0] out_len;
  logic       out_err;

  always #5 clk = ~clk;

  range_sig_decoder #(.MAX_NIBBLES(MAXN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flags(in_flags), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_match(out_match),
    .out_sig(out_sig), .out_len(out_len), .out_err(out_err)
  );

  typedef struct {
    logic       m;
    logic [2:0] s;
    logic [3:0] l;
    logic       e;
  } res_t;

  res_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   rdy_mode = 0;   // 0 random, 1 hold off, 2 always ready
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signature of a key against [lb, ub] from plain integer comparison.
  function automatic logic [2:0] ref_sig(input logic [31:0] a, input logic [31:0] lb, input logic [31:0] ub);
    if (a < lb || a > ub) return 3'b000;
    if (a == lb && a == ub) return 3'b010;
    if (a == ub) return 3'b100;
    if (a == lb) return 3'b001;
    return 3'b111;
  endfunction

  task automatic push(input logic m, input logic [2:0] s, input logic [3:0] l, input logic e);
    res_t r;
    r.m = m; r.s = s; r.l = l; r.e = e;
    q.push_back(r);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted, in_valid still high.
  task automatic drive_beat(input logic [3:0] f, input logic last);
    bit acc = 1'b0;
    bit rdy;
    in_valid = 1'b1;
    in_flags = f;
    in_last  = last;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      acc = rdy;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dir2(input logic [3:0] f0, input logic [3:0] f1,
                      input logic m, input logic [2:0] s, input logic e);
    drive_beat(f0, 1'b0);
    drive_beat(f1, 1'b1);
    push(m, s, 4'd2, e);
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string t);
    @(negedge clk);
    chk({t, "_valid"}, out_valid, 1'b0);
    chk({t, "_match"}, out_match, 1'b0);
    chk({t, "_sig"},   out_sig,   3'b000);
    chk({t, "_len"},   out_len,   4'd0);
    chk({t, "_err"},   out_err,   1'b0);
    chk({t, "_ready"}, in_ready,  1'b1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    chk_idle("rst");
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_key(input bit over);
    int n, badpos;
    bit bad;
    logic [31:0] lb, ub, a, mask, t;
    logic [3:0] an, ln, un, f;
    logic [2:0] s;
    n    = over ? MAXN : $urandom_range(1, MAXN);
    mask = (n == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * n)) - 32'h1);
    lb = $urandom & mask;
    ub = $urandom & mask;
    if ($urandom_range(0, 4) != 0 && lb > ub) begin
      t = lb; lb = ub; ub = t;
    end
    case ($urandom_range(0, 6))
      0: a = lb;
      1: a = ub;
      2: a = (lb + 32'd1) & mask;
      3: a = (ub - 32'd1) & mask;
      4: a = (lb - 32'd1) & mask;
      5: a = (ub + 32'd1) & mask;
      default: a = $urandom & mask;
    endcase
    bad    = ($urandom_range(0, 5) == 0);
    badpos = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      an = 4'((a  >> (4 * (n - 1 - i))) & 32'hF);
      ln = 4'((lb >> (4 * (n - 1 - i))) & 32'hF);
      un = 4'((ub >> (4 * (n - 1 - i))) & 32'hF);
      f  = {an == un, an < un, an == ln, an > ln};
      if (bad && i == badpos) begin
        f = 4'($urandom);
        f = f | (($urandom_range(0, 1) != 0) ? 4'b1100 : 4'b0011);
      end
      if (i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      drive_beat(f, !over && (i == n - 1));
    end
    s = bad ? 3'b000 : ref_sig(a, lb, ub);
    push((s != 3'b000) && !(bad || over), s, 4'(n), bad || over);
    in_valid = 1'b0;
  endtask

  // Sink throttle, updated just after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Scoreboard: a result must be visible exactly while one is owed, and match it while held.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst) begin
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (out_valid && q.size() != 0) begin
          chk("out_match", out_match, q[0].m);
          chk("out_sig",   out_sig,   q[0].s);
          chk("out_len",   out_len,   q[0].l);
          chk("out_err",   out_err,   q[0].e);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_flags = 4'd0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk_idle("post_reset");
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed keys with a sink that always drains.
    rdy_mode = 2;
    dir2(4'b0101, 4'b0101, 1'b1, 3'b111, 1'b0);   // 0x35 in [0x20,0x4F]
    dir2(4'b1010, 4'b1010, 1'b1, 3'b010, 1'b0);   // equal to both bounds
    dir2(4'b1001, 4'b0001, 1'b0, 3'b000, 1'b0);   // UB edge then above
    dir2(4'b1100, 4'b0101, 1'b0, 3'b000, 1'b1);   // illegal beat
    for (int i = 0; i < MAXN; i++) drive_beat(4'b1010, 1'b0);
    push(1'b0, 3'b010, 4'd8, 1'b1);               // overrun closes the key
    drive_beat(4'b1001, 1'b1);                    // fresh key from BOTH
    push(1'b1, 3'b100, 4'd1, 1'b0);
    idle(2);

    // Backpressure: held result blocks input until one ready cycle drains it.
    rdy_mode = 1;
    drive_beat(4'b1010, 1'b1);
    push(1'b1, 3'b010, 4'd1, 1'b0);
    idle(3);
    fork
      begin
        drive_beat(4'b0101, 1'b1);
        push(1'b1, 3'b111, 4'd1, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready", in_ready, 1'b0);
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        rdy_mode = 1;
      end
    join
    idle(3);

    // Reset drops a held result, then reset discards a partial key.
    do_reset();
    rdy_mode = 0;
    drive_beat(4'b0101, 1'b0);
    drive_beat(4'b0101, 1'b0);
    do_reset();
    drive_beat(4'b1010, 1'b1);
    push(1'b1, 3'b010, 4'd1, 1'b0);
    idle(1);

    // Random keys under random sink throttling.
    for (int k = 0; k < 300; k++) begin
      rand_key($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    rdy_mode = 2;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/range_sig_decoder.md
# range_sig_decoder

Serial decoder that turns the per-nibble bound-comparison flags produced by the range bit-vector encoding stages into one final range verdict per key. It sits downstream of the comparison pipeline. It consumes one 4-bit flag beat per key nibble, MSB nibble first, and tracks the prefix relation to the lower and upper bounds in a small state machine. After the last nibble it emits a registered match bit plus the 3-bit stage signature code.

## Interface
- MAX_NIBBLES, 8, maximum beats per key; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low, sampled on clk; one clock, reset is synchronous and active-low.
- in_valid  input  1  flag beat present.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_flags  input  4  {eqU, ltU, eqL, gtL} for this nibble: An==UBn, An<UBn, An==LBn, An>LBn.
- in_last  input  1  beat is the final nibble of the key.
- out_valid  output  1  result held.
- out_ready  input  1  result consumed when out_valid & out_ready.
- out_match  output  1  key inside [LB, UB] inclusive.
- out_sig  output  3  final state code: IN=111, UB=100, LB=001, BOTH=010, OUT=000.
- out_len  output  4  number of beats in the key (1..MAX_NIBBLES).
- out_err  output  1  illegal flags seen, or key overran MAX_NIBBLES.

## Operation
- States: BOTH (prefix equals LB and UB), UB (prefix equals UB and is above LB), LB (prefix equals LB and is below UB), IN (strictly inside), OUT. The idle/start state is BOTH.
- Transitions on each accepted beat:
  - From BOTH:
    - ltU&gtL -> IN
    - eqU&eqL -> BOTH
    - eqU&gtL -> UB
    - eqL&ltU -> LB
    - otherwise -> OUT
  - From UB: ltU -> IN; eqU -> UB; otherwise -> OUT.
  - From LB: gtL -> IN; eqL -> LB; otherwise -> OUT.
  - IN and OUT are absorbing until the key ends.
- Illegal beat: eqU&ltU or eqL&gtL. On an illegal beat the state goes to OUT and a sticky err flag is set for the current key. Further beats of that key are still consumed.
- Beat counter cnt increments on each accepted beat. The key ends when either of these holds:
  - the accepted beat has in_last=1, or
  - the accepted beat brings cnt to MAX_NIBBLES without in_last. This is an overrun: err is set and the key is closed at MAX_NIBBLES.
- Result on key end:
  - out_sig is the code of the next state.
  - out_match = (next state != OUT) & ~err.
  - out_len = cnt+1.
  - out_err = err.
  - The state machine then returns to BOTH and cnt and err clear.
- Beats that arrive after an overrun with in_last=0 start a new key. There is no resynchronisation beyond this.
- in_ready = ~out_valid | out_ready, so a new key may start while a held result drains.

## Timing
- Reset (rst=0 at a clk edge):
  - out_valid=0, out_match=0, out_sig=000, out_len=0, out_err=0.
  - State returns to BOTH; cnt and err clear.
  - in_ready=1 in the cycle after reset.
- Reset mid-key discards the partial key. Reset while a result is held drops the result.
- Latency: out_valid rises on the clock edge that accepts the ending beat, so the result is visible the next cycle. There is one beat per cycle of throughput.
- The output fields are stable while out_valid & ~out_ready.
- If the result is consumed and a new key ends on the same edge, out_valid stays 1 and all fields update to the new key.
- A held, unconsumed result deasserts in_ready; the state machine freezes. There is no overwrite and no loss.
- A 1-beat key (in_last on the first beat) is legal and has out_len=1.

## Test plan
- Key 0x35 vs LB=0x20, UB=0x4F. Beats: {0,1,0,1} with in_last=0, then {0,1,0,1} with in_last=1. Required: out_match=1, out_sig=111, out_len=2, out_err=0, out_valid one cycle after the last beat.
- Key equal to both bounds. Beats {1,0,1,0}, {1,0,1,0} with last. Required: out_sig=010, out_match=1.
- UB edge then above. Beats {1,0,0,1}, then {0,0,0,1} with last. Required: out_sig=000, out_match=0, out_err=0.
- Illegal beat {1,1,0,0} followed by a last beat {0,1,0,1}. Required: out_err=1, out_match=0, out_sig=000, out_len=2.
- Overrun with MAX_NIBBLES=8 and eight beats with in_last=0. Required: result after the 8th beat with out_len=8 and out_err=1. The next beat starts a fresh key from BOTH.
- Backpressure: out_ready=0 while a result is held. Required: in_ready=0, the held result is stable, and the next key's beats are not accepted. Releasing out_ready for one cycle drains the result and resumes acceptance. Asserting rst=0 mid-key clears out_valid and restarts in BOTH.
